// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg: shared definitions for the nibble-serial subtract controller.
//   NIB_W     - width of one subtractor slice step (4 bits)
//   state_t   - controller state encoding (IDLE, RUN, DONE)
//   cnt_width - width of the nibble step counter for a given NIBBLES
package nibble_sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..nibbles-1; never narrower than one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_sub_slice.sv
// nibble_sub_slice: combinational 4-bit borrow-ripple subtractor, d = a - b - bi.
// Ports:
//   bi  in  1      borrow in
//   a   in  NIB_W  minuend nibble
//   b   in  NIB_W  subtrahend nibble
//   d   out NIB_W  difference nibble
//   bo  out 1      borrow out
module nibble_sub_slice
  import nibble_sub_pkg::*;
(
  input  logic             bi,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [NIB_W-1:0] d,
  output logic             bo
);

  // brw_chain[i] is the borrow into bit i; brw_chain[NIB_W] leaves the slice.
  logic [NIB_W:0] brw_chain;

  assign brw_chain[0] = bi;

  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
      assign d[gi]             = a[gi] ^ b[gi] ^ brw_chain[gi];
      assign brw_chain[gi + 1] = (~(a[gi] ^ b[gi]) & brw_chain[gi]) | (~a[gi] & b[gi]);
    end
  endgenerate

  assign bo = brw_chain[NIB_W];

endmodule

// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: nibble-serial multi-word subtractor. One shared 4-bit slice is
// stepped over NIBBLES nibbles, LS nibble first, with the borrow carried in a
// register between steps. Computes diff = a - b - bin (mod 2^WIDTH).
// Optional flags: define SUB_FLAGS_EN to enable the zero/ovf result flags;
// otherwise zero and ovf are tied low.
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      operation request, sampled only while idle
//   bin    in  1      initial borrow-in, captured with the operands
//   a_in   in  WIDTH  minuend
//   b_in   in  WIDTH  subtrahend
//   busy   out 1      high while an operation is running or completing
//   done   out 1      one-cycle pulse, results valid
//   diff   out WIDTH  result, held until the next completion
//   bout   out 1      final borrow-out (a < b + bin, unsigned)
//   zero   out 1      diff == 0
//   ovf    out 1      signed overflow
module nibble_sub_seq
  import nibble_sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     bin,
  input  logic [NIBBLES*NIB_W-1:0] a_in,
  input  logic [NIBBLES*NIB_W-1:0] b_in,
  output logic                     busy,
  output logic                     done,
  output logic [NIBBLES*NIB_W-1:0] diff,
  output logic                     bout,
  output logic                     zero,
  output logic                     ovf
);

  localparam int WIDTH = NIBBLES * NIB_W;
  localparam int CW    = cnt_width(NIBBLES);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] r_sh_reg;
  logic             brw_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  logic [NIB_W-1:0] slice_d;
  logic             slice_bo;
  logic [WIDTH-1:0] r_shift;
  logic             last_step;

  nibble_sub_slice u_slice (
    .bi (brw_reg),
    .a  (a_sh_reg[NIB_W-1:0]),
    .b  (b_sh_reg[NIB_W-1:0]),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // New result nibble enters at the top; after NIBBLES steps the first
  // (least significant) nibble has reached the bottom.
  generate
    if (NIBBLES == 1) begin : g_r_one
      assign r_shift = slice_d;
    end else begin : g_r_many
      assign r_shift = {slice_d, r_sh_reg[WIDTH-1:NIB_W]};
    end
  endgenerate

  assign last_step = (state_reg == RUN) && (cnt_reg == CW'(NIBBLES - 1));

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results are loaded on the edge into DONE so they are already valid
  // during the cycle in which done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      r_sh_reg  <= '0;
      brw_reg   <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg <= a_in;
            b_sh_reg <= b_in;
            brw_reg  <= bin;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> NIB_W;
          b_sh_reg <= b_sh_reg >> NIB_W;
          r_sh_reg <= r_shift;
          brw_reg  <= slice_bo;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_step) begin
            diff_reg <= r_shift;
            bout_reg <= slice_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;

`ifdef SUB_FLAGS_EN
  // Operand sign bits are kept separately because the shift registers
  // have discarded them by the time the result is complete.
  logic a_msb_reg, b_msb_reg;
  logic zero_reg, ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        a_msb_reg <= a_in[WIDTH-1];
        b_msb_reg <= b_in[WIDTH-1];
      end
      if (last_step) begin
        zero_reg <= (r_shift == '0);
        ovf_reg  <= (a_msb_reg != b_msb_reg) && (r_shift[WIDTH-1] != a_msb_reg);
      end
    end
  end

  assign zero = zero_reg;
  assign ovf  = ovf_reg;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_sub_seq.sv
// tb_nibble_sub_seq: directed self-checking bench for nibble_sub_seq.
// Two instances: NIBBLES=4 (16-bit) and NIBBLES=1 (4-bit).
module tb_nibble_sub_seq;

`ifdef SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start4 = 1'b0, bin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, bout4, zero4, ovf4;
  logic [15:0] diff4;

  logic        start1 = 1'b0, bin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, bout1, zero1, ovf1;
  logic [3:0]  diff1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_sub_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin(bin4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
  );

  nibble_sub_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1), .ovf(ovf1)
  );

  // Pulse start on dut4 and wait (bounded) for done; dcyc = cycle of done or -1.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bi,
                     output int dcyc);
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done4 === 1'b1) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
    $display("op4 %h - %h - %0d -> diff=%h bout=%0d zero=%0d ovf=%0d done_cycle=%0d",
             a, b, bi, diff4, bout4, zero4, ovf4, dcyc);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     output int dcyc);
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done1 === 1'b1) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
    $display("op1 %h - %h - %0d -> diff=%h bout=%0d done_cycle=%0d",
             a, b, bi, diff1, bout1, dcyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy4, done4, bout4, zero4, ovf4} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl4: got %b expected 00000", {busy4, done4, bout4, zero4, ovf4});
    end
    n_cmp++; if (diff4 !== 16'h0000) begin
      n_bad++; $display("FAIL reset_diff4: got %h expected 0000", diff4);
    end
    n_cmp++; if ({busy1, done1, bout1, zero1, ovf1, diff1} !== 9'b0) begin
      n_bad++; $display("FAIL reset_dut1: got %b expected 000000000", {busy1, done1, bout1, zero1, ovf1, diff1});
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  // 0x1234 - 0x0001: per-cycle busy/done profile.
  task automatic test_basic();
    logic [15:0] d_at_done;
    logic        bo_at_done;
    d_at_done = 'x; bo_at_done = 1'bx;
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h0001; bin4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      n_cmp++; if (busy4 !== (c >= 1 && c <= 5)) begin
        n_bad++; $display("FAIL basic_busy_c%0d: got %b expected %b", c, busy4, (c >= 1 && c <= 5));
      end
      n_cmp++; if (done4 !== (c == 5)) begin
        n_bad++; $display("FAIL basic_done_c%0d: got %b expected %b", c, done4, (c == 5));
      end
      if (c == 5) begin
        d_at_done = diff4; bo_at_done = bout4;
      end
    end
    $display("op4 1234 - 0001 - 0 -> diff=%h bout=%0d", d_at_done, bo_at_done);
    n_cmp++; if (d_at_done !== 16'h1233) begin
      n_bad++; $display("FAIL basic_diff: got %h expected 1233", d_at_done);
    end
    n_cmp++; if (bo_at_done !== 1'b0) begin
      n_bad++; $display("FAIL basic_bout: got %b expected 0", bo_at_done);
    end
  endtask

  task automatic test_borrow();
    int dc;
    op4(16'h0000, 16'h0001, 1'b0, dc);
    n_cmp++; if (dc !== 5) begin
      n_bad++; $display("FAIL wrap_latency: got %0d expected 5", dc);
    end
    n_cmp++; if ({diff4, bout4} !== {16'hFFFF, 1'b1}) begin
      n_bad++; $display("FAIL wrap_result: got %h/%b expected FFFF/1", diff4, bout4);
    end
    op4(16'h0010, 16'h0000, 1'b1, dc);
    n_cmp++; if ({diff4, bout4} !== {16'h000F, 1'b0} || dc !== 5) begin
      n_bad++; $display("FAIL nibble_borrow: got %h/%b cyc %0d expected 000F/0 cyc 5", diff4, bout4, dc);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone, dcyc;
    logic [15:0] d_at_done;
    ndone = 0; dcyc = -1; d_at_done = 'x;
    @(negedge clk);
    a4 = 16'h00FF; b4 = 16'h000F; bin4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++; dcyc = c; d_at_done = diff4;
      end
      if (c == 2 || c == 5) begin
        start4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; bin4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
    end
    $display("op4 00FF - 000F with busy starts -> dones=%0d cycle=%0d diff=%h", ndone, dcyc, d_at_done);
    n_cmp++; if (ndone !== 1 || dcyc !== 5) begin
      n_bad++; $display("FAIL ignore_done: got %0d dones at %0d expected 1 at 5", ndone, dcyc);
    end
    n_cmp++; if (d_at_done !== 16'h00F0) begin
      n_bad++; $display("FAIL ignore_diff: got %h expected 00F0", d_at_done);
    end
    n_cmp++; if (diff4 !== 16'h00F0 || busy4 !== 1'b0) begin
      n_bad++; $display("FAIL ignore_hold: got %h busy %b expected 00F0 busy 0", diff4, busy4);
    end
  endtask

  task automatic test_abort();
    int ndone, dc;
    ndone = 0;
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h0001; bin4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4 === 1'b1) ndone++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({busy4, done4, bout4} !== 3'b000 || diff4 !== 16'h0000) begin
      n_bad++; $display("FAIL abort_state: got busy %b done %b bout %b diff %h expected 0 0 0 0000",
                        busy4, done4, bout4, diff4);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) ndone++;
    end
    $display("abort after cycle 3 -> dones=%0d diff=%h", ndone, diff4);
    n_cmp++; if (ndone !== 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d expected 0", ndone);
    end
    op4(16'h0005, 16'h0003, 1'b0, dc);
    n_cmp++; if ({diff4, bout4} !== {16'h0002, 1'b0} || dc !== 5) begin
      n_bad++; $display("FAIL abort_recover: got %h/%b cyc %0d expected 0002/0 cyc 5", diff4, bout4, dc);
    end
  endtask

  task automatic test_flags();
    int dc;
    op4(16'h8000, 16'h0001, 1'b0, dc);
    n_cmp++; if ({diff4, bout4} !== {16'h7FFF, 1'b0}) begin
      n_bad++; $display("FAIL flags1_result: got %h/%b expected 7FFF/0", diff4, bout4);
    end
    n_cmp++; if ({zero4, ovf4} !== {1'b0, FLAGS}) begin
      n_bad++; $display("FAIL flags1_zo: got %b%b expected 0%b", zero4, ovf4, FLAGS);
    end
    op4(16'h5555, 16'h5555, 1'b0, dc);
    n_cmp++; if ({diff4, bout4} !== {16'h0000, 1'b0}) begin
      n_bad++; $display("FAIL flags2_result: got %h/%b expected 0000/0", diff4, bout4);
    end
    n_cmp++; if ({zero4, ovf4} !== {FLAGS, 1'b0}) begin
      n_bad++; $display("FAIL flags2_zo: got %b%b expected %b0", zero4, ovf4, FLAGS);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    op1(4'h3, 4'h5, 1'b0, dc);
    n_cmp++; if (dc !== 2) begin
      n_bad++; $display("FAIL n1_latency: got %0d expected 2", dc);
    end
    n_cmp++; if ({diff1, bout1} !== {4'hE, 1'b1}) begin
      n_bad++; $display("FAIL n1_result: got %h/%b expected E/1", diff1, bout1);
    end
    @(negedge clk);
    a1 = 4'h3; b1 = 4'h5; bin1 = 1'b0; start1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_cmp++; if (done1 !== (c % 3 == 2)) begin
        n_bad++; $display("FAIL held_done_c%0d: got %b expected %b", c, done1, (c % 3 == 2));
      end
      if (done1 === 1'b1) begin
        $display("op1 held start cycle %0d -> diff=%h bout=%0d", c, diff1, bout1);
        n_cmp++; if ({diff1, bout1} !== {4'hE, 1'b1}) begin
          n_bad++; $display("FAIL held_result_c%0d: got %h/%b expected E/1", c, diff1, bout1);
        end
      end
    end
    start1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_busy_ignore();
    test_abort();
    test_flags();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
